// File: rtl/tlb_walker.sv
// Hardware page-table walker for Sv32/Sv39/Sv48.
// It takes a TLB miss and issues one PTE read per level, then either
// fills the TLB with the leaf PTE or raises a one-cycle page fault.
// A flush aborts the walk. If a read is still outstanding, the walker
// drains it before returning to idle.
module tlb_walker #(
  parameter int XLEN    = 64,
  parameter int PA_BITS = 56
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [3:0]                          SATP_MODE,
  input  logic [((XLEN == 32) ? 22 : 44)-1:0] SATP_PPN,
  input  logic [XLEN-1:0]                     VAdr,
  input  logic                                TLBMiss,
  input  logic                                TLBFlush,
  output logic                                MemReq,
  output logic [PA_BITS-1:0]                  MemAdr,
  input  logic                                MemReady,
  input  logic                                MemRspValid,
  input  logic [XLEN-1:0]                     MemRspData,
  output logic                                TLBWrite,
  output logic [XLEN-1:0]                     PTE,
  output logic [1:0]                          PageTypeWriteVal,
  output logic                                WalkerPageFault,
  output logic                                Busy
);

  localparam int PPN_W  = (XLEN == 32) ? 22 : 44;
  localparam int VPN_W  = (XLEN == 32) ? 10 : 9;
  localparam int OFF_W  = (XLEN == 32) ? 2 : 3;
  localparam int FULL_W = PPN_W + VPN_W + OFF_W;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_FILL, S_FAULT, S_DRAIN
  } state_t;

  state_t             state;
  logic [1:0]         level;
  logic [PPN_W-1:0]   cur_ppn;
  logic [XLEN-1:0]    pte_q;
  logic [1:0]         page_type;

  logic               mode_valid;
  logic [1:0]         start_level;
  logic [VPN_W-1:0]   vpn;
  logic [XLEN+63:0]   va_ext;
  logic [FULL_W-1:0]  adr_full;
  logic [FULL_W+PA_BITS-1:0] adr_ext;
  logic               pte_bad;
  logic               pte_leaf;
  logic [PPN_W-1:0]   next_ppn;
  logic               unused_bits;

  // Translation mode decode: starting level of the walk, or bare.
  always_comb begin
    mode_valid  = 1'b1;
    start_level = 2'd0;
    case (SATP_MODE)
      4'd1:    start_level = 2'd1;
      4'd8:    start_level = 2'd2;
      4'd9:    start_level = 2'd3;
      default: mode_valid  = 1'b0;
    endcase
  end

  // The extension keeps the upper-level slices in range for Sv32 builds.
  // Those slices are never selected there.
  assign va_ext = {64'd0, VAdr};

  // Select the VPN segment that indexes the current table level.
  always_comb begin
    vpn = va_ext[12 +: VPN_W];
    case (level)
      2'd0:    vpn = va_ext[12 +: VPN_W];
      2'd1:    vpn = va_ext[12 + VPN_W +: VPN_W];
      2'd2:    vpn = va_ext[12 + 2*VPN_W +: VPN_W];
      default: vpn = va_ext[12 + 3*VPN_W +: VPN_W];
    endcase
  end

  // Build the PTE address from the table PPN and the VPN segment.
  // The PTE size sets the byte-offset width.
  // The extension adapts the result to any PA_BITS.
  assign adr_full = {cur_ppn, vpn, {OFF_W{1'b0}}};
  assign adr_ext  = {{PA_BITS{1'b0}}, adr_full};
  assign MemAdr   = adr_ext[PA_BITS-1:0];

  // A write-only PTE is reserved. Superpage alignment and A/D bits are
  // left to the TLB.
  assign pte_bad  = !MemRspData[0] || (!MemRspData[1] && MemRspData[2]);
  assign pte_leaf = MemRspData[1] || MemRspData[3];
  assign next_ppn = MemRspData[10 +: PPN_W];

  assign unused_bits = ^{va_ext, adr_ext};

  // All outputs decode the registered state.
  assign MemReq           = (state == S_REQ);
  assign TLBWrite         = (state == S_FILL);
  assign WalkerPageFault  = (state == S_FAULT);
  assign Busy             = (state != S_IDLE);
  assign PTE              = pte_q;
  assign PageTypeWriteVal = page_type;

  // Walk state machine: one read outstanding at most, flush aborts or drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      level     <= 2'd0;
      cur_ppn   <= '0;
      pte_q     <= '0;
      page_type <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (TLBMiss && !TLBFlush && mode_valid) begin
            state   <= S_REQ;
            level   <= start_level;
            cur_ppn <= SATP_PPN;
          end
        end
        S_REQ: begin
          if (TLBFlush)      state <= MemReady ? S_DRAIN : S_IDLE;
          else if (MemReady) state <= S_WAIT;
        end
        S_WAIT: begin
          if (MemRspValid) begin
            if (TLBFlush)          state <= S_IDLE;
            else if (pte_bad)      state <= S_FAULT;
            else if (pte_leaf) begin
              pte_q     <= MemRspData;
              page_type <= level;
              state     <= S_FILL;
            end
            else if (level == 2'd0) state <= S_FAULT;
            else begin
              cur_ppn <= next_ppn;
              level   <= level - 2'd1;
              state   <= S_REQ;
            end
          end else if (TLBFlush) begin
            state <= S_DRAIN;
          end
        end
        S_FILL:  state <= S_IDLE;
        S_FAULT: state <= S_IDLE;
        S_DRAIN: if (MemRspValid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_walker.sv
// Directed testbench for tlb_walker.
// The main instance is Sv39/Sv48 (XLEN=64); a second instance is Sv32.
// Inputs are driven and outputs sampled on the falling edge.
module tb_tlb_walker;

  logic        clk = 1'b0;
  logic        reset;

  logic [3:0]  mode;
  logic [43:0] ppn;
  logic [63:0] vadr;
  logic        miss, flush, mem_ready, rsp_valid;
  logic [63:0] rsp_data;
  logic        mem_req, tlb_write, fault, busy;
  logic [55:0] mem_adr;
  logic [63:0] pte;
  logic [1:0]  ptype;

  logic [3:0]  s_mode;
  logic [21:0] s_ppn;
  logic [31:0] s_vadr;
  logic        s_miss, s_flush, s_ready, s_rsp_valid;
  logic [31:0] s_rsp_data;
  logic        s_mem_req, s_tlb_write, s_fault, s_busy;
  logic [33:0] s_mem_adr;
  logic [31:0] s_pte;
  logic [1:0]  s_ptype;

  int vectors = 0;
  int miscompares = 0;
  int reads = 0;
  int writes = 0;
  int faults = 0;

  tlb_walker #(.XLEN(64), .PA_BITS(56)) dut (
    .clk(clk), .reset(reset), .SATP_MODE(mode), .SATP_PPN(ppn), .VAdr(vadr),
    .TLBMiss(miss), .TLBFlush(flush), .MemReq(mem_req), .MemAdr(mem_adr),
    .MemReady(mem_ready), .MemRspValid(rsp_valid), .MemRspData(rsp_data),
    .TLBWrite(tlb_write), .PTE(pte), .PageTypeWriteVal(ptype),
    .WalkerPageFault(fault), .Busy(busy)
  );

  tlb_walker #(.XLEN(32), .PA_BITS(34)) dut32 (
    .clk(clk), .reset(reset), .SATP_MODE(s_mode), .SATP_PPN(s_ppn), .VAdr(s_vadr),
    .TLBMiss(s_miss), .TLBFlush(s_flush), .MemReq(s_mem_req), .MemAdr(s_mem_adr),
    .MemReady(s_ready), .MemRspValid(s_rsp_valid), .MemRspData(s_rsp_data),
    .TLBWrite(s_tlb_write), .PTE(s_pte), .PageTypeWriteVal(s_ptype),
    .WalkerPageFault(s_fault), .Busy(s_busy)
  );

  always #5 clk = ~clk;

  // Count accepted reads, fills and faults of the 64-bit walker.
  always @(posedge clk) begin
    if (!reset) begin
      if (mem_req && mem_ready) reads <= reads + 1;
      if (tlb_write)            writes <= writes + 1;
      if (fault)                faults <= faults + 1;
    end
  end

  // Called on a falling edge with the walker idle; returns one cycle later in REQ.
  task automatic start64(input logic [3:0] m, input logic [43:0] p, input logic [63:0] va);
    mode = m; ppn = p; vadr = va; miss = 1'b1;
    @(negedge clk);
    miss = 1'b0;
  endtask

  // Present one response for a single cycle.
  task automatic respond(input logic [63:0] d);
    rsp_valid = 1'b1; rsp_data = d;
    @(negedge clk);
    rsp_valid = 1'b0; rsp_data = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (mem_req !== 1'b0)   begin miscompares++; $display("FAIL rst_memreq got=%0h exp=0", mem_req); end
    vectors++; if (tlb_write !== 1'b0) begin miscompares++; $display("FAIL rst_tlbwrite got=%0h exp=0", tlb_write); end
    vectors++; if (fault !== 1'b0)     begin miscompares++; $display("FAIL rst_fault got=%0h exp=0", fault); end
    vectors++; if (busy !== 1'b0)      begin miscompares++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    vectors++; if (pte !== 64'd0)      begin miscompares++; $display("FAIL rst_pte got=%0h exp=0", pte); end
    vectors++; if (ptype !== 2'd0)     begin miscompares++; $display("FAIL rst_ptype got=%0h exp=0", ptype); end
    vectors++; if (s_busy !== 1'b0)    begin miscompares++; $display("FAIL rst_busy32 got=%0h exp=0", s_busy); end
    reset = 1'b0;
  endtask

  task automatic test_sv39_mega;
    int w0;
    w0 = writes;
    mem_ready = 1'b1;
    start64(4'd8, 44'h80000, 64'h80201000);
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL mega_req2 got=%0h exp=1", mem_req); end
    vectors++; if (mem_adr !== 56'h80000010) begin miscompares++; $display("FAIL mega_adr2 got=%0h exp=80000010", mem_adr); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mega_busy got=%0h exp=1", busy); end
    @(negedge clk);
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL mega_wait_req got=%0h exp=0", mem_req); end
    respond(64'h20000401);
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL mega_req1 got=%0h exp=1", mem_req); end
    vectors++; if (mem_adr !== 56'h80001008) begin miscompares++; $display("FAIL mega_adr1 got=%0h exp=80001008", mem_adr); end
    @(negedge clk);
    respond(64'h200008CF);
    vectors++; if (tlb_write !== 1'b1) begin miscompares++; $display("FAIL mega_write got=%0h exp=1", tlb_write); end
    vectors++; if (pte !== 64'h200008CF) begin miscompares++; $display("FAIL mega_pte got=%0h exp=200008cf", pte); end
    vectors++; if (ptype !== 2'd1) begin miscompares++; $display("FAIL mega_ptype got=%0h exp=1", ptype); end
    @(negedge clk);
    vectors++; if (tlb_write !== 1'b0) begin miscompares++; $display("FAIL mega_write_pulse got=%0h exp=0", tlb_write); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mega_idle got=%0h exp=0", busy); end
    vectors++; if (writes - w0 !== 1) begin miscompares++; $display("FAIL mega_nwrites got=%0d exp=1", writes - w0); end
  endtask

  task automatic test_sv32_invalid;
    s_ready = 1'b1; s_mode = 4'd1; s_ppn = 22'h1; s_vadr = 32'h00400000; s_miss = 1'b1;
    @(negedge clk);
    s_miss = 1'b0;
    vectors++; if (s_mem_req !== 1'b1) begin miscompares++; $display("FAIL sv32_req got=%0h exp=1", s_mem_req); end
    vectors++; if (s_mem_adr !== 34'h1004) begin miscompares++; $display("FAIL sv32_adr got=%0h exp=1004", s_mem_adr); end
    @(negedge clk);
    s_rsp_valid = 1'b1; s_rsp_data = 32'h0;
    @(negedge clk);
    s_rsp_valid = 1'b0;
    vectors++; if (s_fault !== 1'b1) begin miscompares++; $display("FAIL sv32_fault got=%0h exp=1", s_fault); end
    vectors++; if (s_tlb_write !== 1'b0) begin miscompares++; $display("FAIL sv32_nowrite got=%0h exp=0", s_tlb_write); end
    @(negedge clk);
    vectors++; if (s_fault !== 1'b0) begin miscompares++; $display("FAIL sv32_fault_pulse got=%0h exp=0", s_fault); end
    vectors++; if (s_busy !== 1'b0) begin miscompares++; $display("FAIL sv32_idle got=%0h exp=0", s_busy); end
  endtask

  task automatic test_nonleaf_l0;
    int r0, w0, f0;
    logic [63:0] rsps [3];
    logic [55:0] adrs [3];
    rsps[0] = 64'h401; rsps[1] = 64'h801; rsps[2] = 64'hC01;
    adrs[0] = 56'h80000000; adrs[1] = 56'h1000; adrs[2] = 56'h2000;
    r0 = reads; w0 = writes; f0 = faults;
    mem_ready = 1'b1;
    start64(4'd8, 44'h80000, 64'h0);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (mem_adr !== adrs[i]) begin miscompares++; $display("FAIL nl_adr%0d got=%0h exp=%0h", i, mem_adr, adrs[i]); end
      @(negedge clk);
      respond(rsps[i]);
    end
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL nl_fault got=%0h exp=1", fault); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL nl_idle got=%0h exp=0", busy); end
    vectors++; if (reads - r0 !== 3) begin miscompares++; $display("FAIL nl_reads got=%0d exp=3", reads - r0); end
    vectors++; if (writes !== w0) begin miscompares++; $display("FAIL nl_writes got=%0d exp=%0d", writes, w0); end
    vectors++; if (faults - f0 !== 1) begin miscompares++; $display("FAIL nl_faults got=%0d exp=1", faults - f0); end
  endtask

  task automatic test_backpressure;
    int r0;
    logic [55:0] adrs [2];
    logic [63:0] rsps [2];
    adrs[0] = 56'h80000008; adrs[1] = 56'h80001008;
    rsps[0] = 64'h20000401; rsps[1] = 64'h200000CF;
    r0 = reads;
    mem_ready = 1'b0;
    start64(4'd8, 44'h80000, 64'h40200000);
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 4; c++) begin
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL bp_req l%0d c%0d got=%0h exp=1", l, c, mem_req); end
        vectors++; if (mem_adr !== adrs[l]) begin miscompares++; $display("FAIL bp_adr l%0d c%0d got=%0h exp=%0h", l, c, mem_adr, adrs[l]); end
        miss = 1'b1;
        if (c == 3) mem_ready = 1'b1;
        @(negedge clk);
      end
      miss = 1'b0;
      mem_ready = 1'b0;
      respond(rsps[l]);
    end
    vectors++; if (tlb_write !== 1'b1) begin miscompares++; $display("FAIL bp_write got=%0h exp=1", tlb_write); end
    vectors++; if (pte !== 64'h200000CF) begin miscompares++; $display("FAIL bp_pte got=%0h exp=200000cf", pte); end
    vectors++; if (reads - r0 !== 2) begin miscompares++; $display("FAIL bp_reads got=%0d exp=2", reads - r0); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bp_idle got=%0h exp=0", busy); end
    mem_ready = 1'b1;
  endtask

  task automatic test_blocked;
    mode = 4'd0; miss = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bare_busy got=%0h exp=0", busy); end
    mode = 4'd8; flush = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_idle_busy got=%0h exp=0", busy); end
    miss = 1'b0; flush = 1'b0;
  endtask

  task automatic test_flush_req;
    int r0, w0;
    r0 = reads; w0 = writes;
    mem_ready = 1'b0;
    start64(4'd8, 44'h80000, 64'h80201000);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL freq_abort_busy got=%0h exp=0", busy); end
    vectors++; if (reads !== r0) begin miscompares++; $display("FAIL freq_abort_reads got=%0d exp=%0d", reads, r0); end
    start64(4'd8, 44'h80000, 64'h80201000);
    mem_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL freq_drain_busy got=%0h exp=1", busy); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL freq_drain_req got=%0h exp=0", mem_req); end
    respond(64'h200008CF);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL freq_drained got=%0h exp=0", busy); end
    vectors++; if (tlb_write !== 1'b0) begin miscompares++; $display("FAIL freq_nowrite got=%0h exp=0", tlb_write); end
    vectors++; if (reads - r0 !== 1) begin miscompares++; $display("FAIL freq_reads got=%0d exp=1", reads - r0); end
  endtask

  task automatic test_flush_wait;
    int w0, f0;
    w0 = writes; f0 = faults;
    mem_ready = 1'b1;
    start64(4'd8, 44'h80000, 64'h80201000);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fw_drain_busy got=%0h exp=1", busy); end
    @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL fw_drain_hold got=%0h exp=1", busy); end
    respond(64'h200008CF);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL fw_idle got=%0h exp=0", busy); end
    vectors++; if (tlb_write !== 1'b0) begin miscompares++; $display("FAIL fw_nowrite got=%0h exp=0", tlb_write); end
    respond(64'h200008CF);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stray_busy got=%0h exp=0", busy); end
    @(negedge clk);
    vectors++; if (writes !== w0) begin miscompares++; $display("FAIL fw_writes got=%0d exp=%0d", writes, w0); end
    vectors++; if (faults !== f0) begin miscompares++; $display("FAIL fw_faults got=%0d exp=%0d", faults, f0); end
  endtask

  task automatic test_reset_wait;
    int w0;
    w0 = writes;
    mem_ready = 1'b1;
    start64(4'd8, 44'h80000, 64'h80201000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rw_busy got=%0h exp=0", busy); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rw_req got=%0h exp=0", mem_req); end
    vectors++; if (pte !== 64'd0) begin miscompares++; $display("FAIL rw_pte got=%0h exp=0", pte); end
    vectors++; if (ptype !== 2'd0) begin miscompares++; $display("FAIL rw_ptype got=%0h exp=0", ptype); end
    @(negedge clk);
    reset = 1'b0;
    respond(64'h200008CF);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rw_late_busy got=%0h exp=0", busy); end
    vectors++; if (tlb_write !== 1'b0) begin miscompares++; $display("FAIL rw_late_write got=%0h exp=0", tlb_write); end
    @(negedge clk);
    vectors++; if (writes !== w0) begin miscompares++; $display("FAIL rw_writes got=%0d exp=%0d", writes, w0); end
  endtask

  initial begin
    reset = 1'b1;
    mode = 4'd0; ppn = '0; vadr = '0; miss = 1'b0; flush = 1'b0;
    mem_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    s_mode = 4'd0; s_ppn = '0; s_vadr = '0; s_miss = 1'b0; s_flush = 1'b0;
    s_ready = 1'b0; s_rsp_valid = 1'b0; s_rsp_data = '0;
    test_reset;
    test_sv39_mega;
    test_sv32_invalid;
    test_nonleaf_l0;
    test_backpressure;
    test_blocked;
    test_flush_req;
    test_flush_wait;
    test_reset_wait;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1);
  end

endmodule
